hilo_mdu: RTL and testbench

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/mdu_pkg.sv | 19 +
 rtl/div_iter.sv | 69 ++++++
 rtl/hilo_mdu.sv | 102 ++++++++++
 tb/tb_hilo_mdu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared state type, divide length and ALU op codes for the HI/LO unit
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_e;

  localparam int DIV_CYCLES = 32;

  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MTHI  = 5'd20;
  localparam logic [4:0] ALU_MTLO  = 5'd21;

  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - 32-step restoring divider on magnitudes with sign fix-up of the final step
module div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  input  logic        flush_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        ready_o
);

  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic        qneg_q, rneg_q;
  logic [32:0] shifted, diff;

  // Dividend bits shift out of quo_q into the partial remainder as quotient bits shift in.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = shifted[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
  end

  assign ready_o     = busy_q && (cnt_q == 5'(DIV_CYCLES - 1));
  assign quotient_o  = neg_if(qneg_q, quo_d);
  assign remainder_o = neg_if(rneg_q, rem_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= neg_if(signed_i & a_i[31], a_i);
      dvs_q  <= neg_if(signed_i & b_i[31], b_i);
      qneg_q <= signed_i & (a_i[31] ^ b_i[31]);
      rneg_q <= signed_i & a_i[31];
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 5'd1;
      if (ready_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO multiply/divide unit; HILO_BYPASS_EN forwards the pending write to hi_o/lo_o
module hilo_mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall,
  output logic        done
);

  mdu_state_e  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        stall_c, div_start, div_ready;
  logic [31:0] div_quo, div_rem;
  logic [63:0] prod_s, prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  div_iter u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .a_i        (a),
    .b_i        (b),
    .signed_i   (op == ALU_DIV),
    .flush_i    (flush),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .ready_o    (div_ready)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_c   = 1'b0;
    done      = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (en && !flush) begin
        case (op)
          ALU_MULT:  {hi_d, lo_d} = prod_s;
          ALU_MULTU: {hi_d, lo_d} = prod_u;
          ALU_MTHI:  hi_d = a;
          ALU_MTLO:  lo_d = a;
          ALU_DIV, ALU_DIVU: if (b != 32'd0) begin
            stall_c   = 1'b1;
            div_start = 1'b1;
            state_d   = RUN;
          end
          default: ;
        endcase
      end
      RUN: begin
        stall_c = !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (div_ready) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = stall_c & ~rst;

`ifdef HILO_BYPASS_EN
  assign hi_o = hi_d;
  assign lo_o = lo_d;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - vector table, random ops against an arithmetic model, flush/reset sequences
module tb_hilo_mdu;
  import mdu_pkg::*;

  logic        clk, rst, en, flush;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi_o, lo_o;
  logic        stall, done;

  hilo_mdu dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .a(a), .b(b), .flush(flush),
    .hi_o(hi_o), .lo_o(lo_o), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    logic [31:0] hi;
    logic [31:0] lo;
    int          st;
  } vec_t;

  vec_t        tab[15];
  int          n_vec, n_bad;
  int          st_cnt, dn_cnt;
  logic [31:0] done_hi, done_lo;
  logic [31:0] m_hi, m_lo;
  logic [4:0]  ops[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Presents one op for one cycle, then follows any stall/done tail (bounded).
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic f);
    en = 1'b1; op = o; a = x; b = y; flush = f;
    st_cnt = 0; dn_cnt = 0;
    #2;
    if (stall) st_cnt++;
    @(posedge clk); #1;
    en = 1'b0; op = 5'd0; a = '0; b = '0; flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) begin
        dn_cnt++;
        done_hi = hi_o;
        done_lo = lo_o;
      end
      if (stall) st_cnt++;
      if (!stall && !done) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic f, output int st);
    logic [63:0] p;
    longint      sx, sy;
    st = 0;
    if (!f) begin
      case (o)
        ALU_MULT: begin
          p = 64'(longint'($signed(x)) * longint'($signed(y)));
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        ALU_MULTU: begin
          p = {32'd0, x} * {32'd0, y};
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        ALU_DIV: if (y != 0) begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          p = 64'(sx / sy); m_lo = p[31:0];
          p = 64'(sx % sy); m_hi = p[31:0];
          st = 33;
        end
        ALU_DIVU: if (y != 0) begin
          m_lo = x / y; m_hi = x % y; st = 33;
        end
        ALU_MTHI: m_hi = x;
        ALU_MTLO: m_lo = x;
        default: ;
      endcase
    end
  endtask

  task automatic check_after(input string tag, input int est);
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
    chk({tag, " stall cycles"}, 32'(st_cnt), 32'(est));
    chk({tag, " done pulses"}, 32'(dn_cnt), (est != 0) ? 32'd1 : 32'd0);
    if (est != 0) begin
      chk({tag, " hi in done"}, done_hi, m_hi);
      chk({tag, " lo in done"}, done_lo, m_lo);
    end
  endtask

  initial begin
    int est;
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    logic        rf;
    n_vec = 0; n_bad = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;

    tab[0]  = '{ALU_MTHI,  32'h11,       32'h0,       1'b0, 32'h11,       32'h0,       0};
    tab[1]  = '{ALU_MTLO,  32'h22,       32'h0,       1'b0, 32'h11,       32'h22,      0};
    tab[2]  = '{ALU_DIVU,  32'd5,        32'd0,       1'b0, 32'h11,       32'h22,      0};
    tab[3]  = '{ALU_MTHI,  32'hDEAD,     32'h0,       1'b1, 32'h11,       32'h22,      0};
    tab[4]  = '{ALU_DIV,   32'd9,        32'd2,       1'b1, 32'h11,       32'h22,      0};
    tab[5]  = '{ALU_MULT,  32'hFFFFFFFE, 32'd3,       1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
    tab[6]  = '{ALU_MULTU, 32'hFFFFFFFE, 32'd3,       1'b0, 32'h00000002, 32'hFFFFFFFA, 0};
    tab[7]  = '{ALU_DIV,   32'hFFFFFFF9, 32'd2,       1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tab[8]  = '{ALU_DIVU,  32'd100,      32'd7,       1'b0, 32'd2,        32'd14,      33};
    tab[9]  = '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,       32'h80000000, 33};
    tab[10] = '{ALU_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,       32'hFFFFFFFD, 33};
    tab[11] = '{5'd0,      32'd1,        32'd2,       1'b0, 32'd1,        32'hFFFFFFFD, 0};
    tab[12] = '{ALU_DIVU,  32'hFFFFFFFF, 32'd1,       1'b0, 32'h0,        32'hFFFFFFFF, 33};
    tab[13] = '{ALU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFE, 32'd2,      33};
    tab[14] = '{ALU_DIV,   32'd0,        32'd5,       1'b0, 32'h0,        32'h0,       33};

    ops = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO, 5'd0, 5'd31};

    #12;
    chk("reset hi", hi_o, 32'h0);
    chk("reset lo", lo_o, 32'h0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tab[i]) begin
      issue(tab[i].op, tab[i].a, tab[i].b, tab[i].fl);
      m_hi = tab[i].hi; m_lo = tab[i].lo;
      check_after($sformatf("vec%0d", i), tab[i].st);
    end

    for (int i = 0; i < 50; i++) begin
      ro = ops[$urandom_range(0, 7)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 5) == 0) ra = {1'b1, ra[30:0]};
      rf = ($urandom_range(0, 9) == 0);
      issue(ro, ra, rb, rf);
      model(ro, ra, rb, rf, est);
      check_after($sformatf("rnd%0d op%0d", i, ro), est);
    end

    // Flush on RUN cycle 10 abandons the divide; a move right after is accepted.
    en = 1'b1; op = ALU_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("run10 stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    chk("flush stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; #1;
    chk("post-flush stall", {31'd0, stall}, 32'd0);
    chk("post-flush done", {31'd0, done}, 32'd0);
    chk("post-flush hi", hi_o, m_hi);
    chk("post-flush lo", lo_o, m_lo);
    issue(ALU_MTLO, 32'hABCD, 32'd0, 1'b0);
    model(ALU_MTLO, 32'hABCD, 32'd0, 1'b0, est);
    check_after("mtlo after flush", est);

    // Reset on RUN cycle 20 aborts the divide and clears HI/LO.
    en = 1'b1; op = ALU_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    chk("after rst stall", {31'd0, stall}, 32'd0);
    chk("after rst done", {31'd0, done}, 32'd0);
    en = 1'b1; op = ALU_MTHI; a = 32'h1234; #1;
`ifdef HILO_BYPASS_EN
    chk("mthi same cycle", hi_o, 32'h1234);
`else
    chk("mthi same cycle", hi_o, 32'h0);
`endif
    @(posedge clk); #1;
    en = 1'b0; #1;
    chk("mthi next cycle", hi_o, 32'h1234);
    chk("mthi lo kept", lo_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
